// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, synchronous flush and bubble-safe control outputs.
// SKID=1 gives a two-entry skid buffer with registered ready_o; define PIPE_STAGE_PERF_EN for stall/bubble counters.
module pipe_stage_reg #(
  parameter int CTRL_W = 4,
  parameter int DATA_W = 69,
  parameter int SKID   = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              flush_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       bubble_cnt_o
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  logic              in_fire;
  logic              out_fire;
  logic              main_valid;
  logic              main_load;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl_nx;
  logic [DATA_W-1:0] main_data_nx;

  assign in_fire  = valid_i & ready_o;
  assign out_fire = valid_o & ready_i;

  assign valid_o = main_valid;
  // Control bits are gated so a bubble can never write a register or memory downstream.
  assign ctrl_o  = main_valid ? main_ctrl : '0;
  assign data_o  = main_data;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      main_ctrl <= '0;
      main_data <= '0;
    end else if (main_load) begin
      main_ctrl <= main_ctrl_nx;
      main_data <= main_data_nx;
    end
  end

  if (SKID != 0) begin : g_skid
    state_t            state;
    state_t            state_nx;
    logic              ready_q;
    logic              load_main_in;
    logic              load_main_skid;
    logic              load_skid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        state   <= ST_EMPTY;
        ready_q <= 1'b0;
      end else begin
        state   <= state_nx;
        ready_q <= (state_nx != ST_FULL);
      end
    end

    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    always_comb begin
      state_nx       = state;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      if (flush_i) begin
        state_nx = ST_EMPTY;
      end else begin
        unique case (state)
          ST_EMPTY: begin
            if (in_fire) begin
              state_nx     = ST_ONE;
              load_main_in = 1'b1;
            end
          end
          ST_ONE: begin
            case ({in_fire, out_fire})
              2'b11: load_main_in = 1'b1;
              2'b10: begin
                state_nx  = ST_FULL;
                load_skid = 1'b1;
              end
              2'b01: state_nx = ST_EMPTY;
              default: ;
            endcase
          end
          ST_FULL: begin
            // ready_o is low here, so only the older entry can leave; the skid entry takes its place.
            if (out_fire) begin
              state_nx       = ST_ONE;
              load_main_skid = 1'b1;
            end
          end
          default: state_nx = ST_EMPTY;
        endcase
      end
    end

    // NOTE: the skid payload is not reset; it is only ever read after being written in the FULL path.
    always_ff @(posedge clk_i) begin
      if (load_skid) begin
        skid_ctrl <= ctrl_i;
        skid_data <= data_i;
      end
    end

    assign ready_o      = ready_q;
    assign main_valid   = (state != ST_EMPTY);
    assign main_load    = load_main_in | load_main_skid;
    assign main_ctrl_nx = load_main_skid ? skid_ctrl : ctrl_i;
    assign main_data_nx = load_main_skid ? skid_data : data_i;
  end else begin : g_single
    logic valid_q;
    logic rst_done_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        valid_q    <= 1'b0;
        rst_done_q <= 1'b0;
      end else begin
        rst_done_q <= 1'b1;
        if (flush_i) begin
          valid_q <= 1'b0;
        end else if (in_fire) begin
          valid_q <= 1'b1;
        end else if (out_fire) begin
          valid_q <= 1'b0;
        end
      end
    end

    // rst_done_q keeps ready_o low until the first edge after reset without a reset-to-output path.
    assign ready_o      = rst_done_q & (ready_i | ~valid_q);
    assign main_valid   = valid_q;
    assign main_load    = in_fire & ~flush_i;
    assign main_ctrl_nx = ctrl_i;
    assign main_data_nx = data_i;
  end

`ifdef PIPE_STAGE_PERF_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_o  <= '0;
      bubble_cnt_o <= '0;
    end else begin
      if (valid_o && !ready_i && (stall_cnt_o != 32'hFFFF_FFFF)) begin
        stall_cnt_o <= stall_cnt_o + 32'd1;
      end
      if (!valid_o && (bubble_cnt_o != 32'hFFFF_FFFF)) begin
        bubble_cnt_o <= bubble_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter CTRL_W, default 4; control-field width (RegWrite, MemToReg, MemRead, MemWrite); range 1..16.
REQ-002 SHALL have parameter DATA_W, default 69; payload width (ALU result, read data 2, rd index); range 1..256.
REQ-003 SHALL have parameter SKID, default 1; 1 = two-entry skid buffer with registered ready_o, 0 = single register.
REQ-004 SHALL have port clk_i  in  1  clock; all state updates on rising edge.
REQ-005 SHALL have port rst_i  in  1  reset; asynchronous, active-high.
REQ-006 SHALL have port valid_i  in  1  upstream entry valid.
REQ-007 SHALL have port ready_o  out  1  stage can accept an entry.
REQ-008 SHALL have port ctrl_i  in  CTRL_W  upstream control bits.
REQ-009 SHALL have port data_i  in  DATA_W  upstream payload.
REQ-010 SHALL have port flush_i  in  1  synchronous squash of all held entries.
REQ-011 SHALL have port valid_o  out  1  downstream entry valid.
REQ-012 SHALL have port ready_i  in  1  downstream accepts.
REQ-013 SHALL have port ctrl_o  out  CTRL_W  downstream control bits.
REQ-014 SHALL have port data_o  out  DATA_W  downstream payload.

Function
REQ-015 SHALL treat an accept as valid_i & ready_o at a rising edge, and a release as valid_o & ready_i at a rising edge.
REQ-016 SHALL present an accepted entry on valid_o/ctrl_o/data_o exactly 1 cycle after the accept when the stage was empty or releasing.
REQ-017 SHALL sustain one accept and one release per cycle while ready_i=1 (no bubbles inserted).
REQ-018 SHALL, with SKID=1, implement states EMPTY, ONE, FULL: EMPTY->ONE on accept; ONE->FULL on accept without release; ONE->EMPTY on release without accept; FULL->ONE on release; otherwise hold.
REQ-019 SHALL, with SKID=1, drive ready_o from a register: 1 in EMPTY/ONE, 0 in FULL; no combinational path from ready_i to ready_o.
REQ-020 SHALL, in FULL, emit the older (main) entry first, then move the skid entry into main on release, preserving order.
REQ-021 SHALL, with SKID=0, drive ready_o = ready_i | ~valid_o and hold the single entry while ready_i=0.
REQ-022 SHALL force ctrl_o to all zeros whenever valid_o=0, so a bubble never asserts a control bit.
REQ-023 SHALL hold data_o at its last value when valid_o=0 (no zeroing of payload).
REQ-024 SHALL hold main-entry contents stable while valid_o=1 and ready_i=0.
REQ-025 SHALL, on flush_i=1 at an edge, clear all valid bits (state EMPTY) and discard any simultaneous accept; flush dominates accept and release.
REQ-026 SHALL assert ready_o=1 in the cycle after a flush.

Reset
REQ-027 SHALL, while rst_i=1, immediately force state EMPTY, valid_o=0, ctrl_o=0, data_o=0, ready_o=0.
REQ-028 SHALL assert ready_o=1 on the first rising edge after rst_i deasserts; reset mid-transfer discards both entries.

Configuration
REQ-029 SHALL, when macro PIPE_STAGE_PERF_EN is defined, add outputs stall_cnt_o (32, cycles with valid_o & ~ready_i) and bubble_cnt_o (32, cycles with valid_o=0), both reset to 0, saturating at 0xFFFFFFFF, cleared by rst_i only.
REQ-030 SHALL, without PIPE_STAGE_PERF_EN, omit both ports and counters; all other behaviour identical.

Verification
REQ-031 Reset then valid_i=1, ctrl_i=4'b1001, data_i=69'h1234, ready_i=1 -> next cycle valid_o=1, ctrl_o=4'b1001, data_o=69'h1234.
REQ-032 SKID=1, stream A,B,C with ready_i=0 from cycle 1 -> ready_o=0 after A,B held; ready_i=1 -> outputs A then B then C, no loss/duplication.
REQ-033 Accept entry with ctrl 4'b1111, then flush_i=1 with valid_i=1 -> next cycle valid_o=0, ctrl_o=4'b0000, ready_o=1, new entry dropped.
REQ-034 Continuous 100-entry stream with ready_i=1 -> 100 outputs in 100 consecutive cycles, latency 1.
REQ-035 rst_i asserted mid-cycle while FULL -> valid_o, ctrl_o, data_o go 0 before next edge; ready_o=1 one edge after release.
REQ-036 PIPE_STAGE_PERF_EN defined, ready_i=0 for 7 cycles with valid_o=1 -> stall_cnt_o=7; bubble_cnt_o counts idle cycles from reset.
